fb_mem_arbiter: RTL and testbench

Shares the single-port 32-bit on-chip frame memory (76800 words, 17-bit word address, 1-cycle read latency) between two Avalon-MM style requesters, e.g. the CPU data master and the touch/WiFi drawing engine. Arbitration is round-robin. A built-in fill sequencer clears or paints the whole memory to a constant word on command. Sits between the requesters and the memory's address/byteenable/chipselect/write/writedata/readdata ports; the memory clock enable is tied high at the top level.

---
 rtl/fb_mem_arbiter.sv | 221 ++++++++++++++++++++++
 tb/tb_fb_mem_arbiter.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fb_mem_arbiter.sv
// fb_mem_arbiter
//   Shares the single-port frame memory between two Avalon-MM style requesters
//   (m0, m1) with round-robin arbitration, and provides a fill sequencer that
//   writes one constant word to every location on command.
//
// Ports
//   clk, reset                 clock, asynchronous active-high reset
//   m0_* / m1_*                requester address/byteenable/read/write/writedata
//                              in; waitrequest/readdata/readdatavalid out
//   fill_start, fill_value     start pulse and word to paint (latched at start)
//   fill_busy, fill_done       fill in progress / one-cycle completion pulse
//   mem_*                      address/byteenable/chipselect/write/writedata to
//                              the memory, readdata back (1-cycle latency)
module fb_mem_arbiter #(
   parameter int unsigned ADDR_W = 17,
   parameter int unsigned DEPTH  = 76800,
   parameter int unsigned DATA_W = 32
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [ADDR_W-1:0]   m0_address,
   input  logic [DATA_W/8-1:0] m0_byteenable,
   input  logic                m0_read,
   input  logic                m0_write,
   input  logic [DATA_W-1:0]   m0_writedata,
   output logic                m0_waitrequest,
   output logic [DATA_W-1:0]   m0_readdata,
   output logic                m0_readdatavalid,
   input  logic [ADDR_W-1:0]   m1_address,
   input  logic [DATA_W/8-1:0] m1_byteenable,
   input  logic                m1_read,
   input  logic                m1_write,
   input  logic [DATA_W-1:0]   m1_writedata,
   output logic                m1_waitrequest,
   output logic [DATA_W-1:0]   m1_readdata,
   output logic                m1_readdatavalid,
   input  logic                fill_start,
   input  logic [DATA_W-1:0]   fill_value,
   output logic                fill_busy,
   output logic                fill_done,
   output logic [ADDR_W-1:0]   mem_address,
   output logic [DATA_W/8-1:0] mem_byteenable,
   output logic                mem_chipselect,
   output logic                mem_write,
   output logic [DATA_W-1:0]   mem_writedata,
   input  logic [DATA_W-1:0]   mem_readdata
);

   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_FILL,
      S_DONE
   } state_t;

   state_t state;
   state_t state_nx;

   // last_grant: 0 = m0 granted most recently, 1 = m1
   logic                last_grant;
   logic [ADDR_W-1:0]   fill_cnt;
   logic [DATA_W-1:0]   fill_val;

   logic                pend_valid;
   logic                pend_id;
   logic                pend_oor;
   logic [DATA_W-1:0]   rd_hold0;
   logic [DATA_W-1:0]   rd_hold1;
   logic [DATA_W-1:0]   rd_ret;

   logic                req0;
   logic                req1;
   logic                grant0;
   logic                grant1;
   logic                gnt_any;
   logic [ADDR_W-1:0]   g_addr;
   logic [DATA_W/8-1:0] g_be;
   logic [DATA_W-1:0]   g_data;
   logic                g_read;
   logic                g_write;
   logic                in_range;

   assign req0 = m0_read | m0_write;
   assign req1 = m1_read | m1_write;

   // Round-robin: on a tie the master that was not granted last wins.
   always_comb begin
      grant0 = 1'b0;
      grant1 = 1'b0;
      if (state == S_IDLE) begin
         if (req0 && (!req1 || last_grant)) begin
            grant0 = 1'b1;
         end else if (req1) begin
            grant1 = 1'b1;
         end
      end
   end

   assign gnt_any  = grant0 | grant1;
   assign g_addr   = grant1 ? m1_address    : m0_address;
   assign g_be     = grant1 ? m1_byteenable : m0_byteenable;
   assign g_data   = grant1 ? m1_writedata  : m0_writedata;
   assign g_read   = grant1 ? m1_read       : m0_read;
   assign g_write  = grant1 ? m1_write      : m0_write;
   assign in_range = (g_addr <= LAST_ADDR);

   // State register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= S_IDLE;
      end else begin
         state <= state_nx;
      end
   end

   // Next-state logic
   always_comb begin
      state_nx = state;
      case (state)
         S_IDLE: if (fill_start) state_nx = S_FILL;
         S_FILL: if (fill_cnt == LAST_ADDR) state_nx = S_DONE;
         S_DONE: state_nx = S_IDLE;
         default: state_nx = S_IDLE;
      endcase
   end

   // Datapath registers: fill counter/value, arbitration history, read return
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         fill_cnt   <= '0;
         fill_val   <= '0;
         last_grant <= 1'b1;
         pend_valid <= 1'b0;
         pend_id    <= 1'b0;
         pend_oor   <= 1'b0;
         rd_hold0   <= '0;
         rd_hold1   <= '0;
      end else begin
         if (state == S_IDLE && fill_start) begin
            fill_val <= fill_value;
            fill_cnt <= '0;
         end else if (state == S_FILL && fill_cnt != LAST_ADDR) begin
            fill_cnt <= fill_cnt + 1'b1;
         end

         if (grant0) begin
            last_grant <= 1'b0;
         end else if (grant1) begin
            last_grant <= 1'b1;
         end

         // Read+write together is a write, so no return is scheduled.
         pend_valid <= gnt_any && g_read && !g_write;
         pend_id    <= grant1;
         pend_oor   <= !in_range;

         // Readdata is driven straight from memory in the valid cycle and
         // captured here so the output holds afterwards.
         if (pend_valid) begin
            if (pend_id) begin
               rd_hold1 <= rd_ret;
            end else begin
               rd_hold0 <= rd_ret;
            end
         end
      end
   end

   assign rd_ret = pend_oor ? '0 : mem_readdata;

   // Output logic
   always_comb begin
      mem_address    = '0;
      mem_byteenable = '0;
      mem_chipselect = 1'b0;
      mem_write      = 1'b0;
      mem_writedata  = '0;
      m0_waitrequest = 1'b0;
      m1_waitrequest = 1'b0;
      case (state)
         S_IDLE: begin
            m0_waitrequest = req0 & ~grant0;
            m1_waitrequest = req1 & ~grant1;
            if (gnt_any) begin
               mem_address    = g_addr;
               mem_byteenable = g_be;
               mem_writedata  = g_data;
               mem_chipselect = in_range;
               mem_write      = g_write;
            end
         end
         S_FILL: begin
            m0_waitrequest = 1'b1;
            m1_waitrequest = 1'b1;
            mem_address    = fill_cnt;
            mem_byteenable = '1;
            mem_writedata  = fill_val;
            mem_chipselect = 1'b1;
            mem_write      = 1'b1;
         end
         S_DONE: begin
            m0_waitrequest = 1'b1;
            m1_waitrequest = 1'b1;
         end
         default: begin
            m0_waitrequest = 1'b1;
            m1_waitrequest = 1'b1;
         end
      endcase
   end

   assign fill_busy = (state == S_FILL);
   assign fill_done = (state == S_DONE);

   assign m0_readdatavalid = pend_valid & ~pend_id;
   assign m1_readdatavalid = pend_valid &  pend_id;
   assign m0_readdata      = m0_readdatavalid ? rd_ret : rd_hold0;
   assign m1_readdata      = m1_readdatavalid ? rd_ret : rd_hold1;

endmodule

// File: tb/tb_fb_mem_arbiter.sv
// tb_fb_mem_arbiter
//   Bench for fb_mem_arbiter: attaches a 1-cycle-latency memory, drives
//   directed transactions, and checks every cycle against a transaction-level
//   model plus literal expectations for the key scenarios.
module tb_fb_mem_arbiter;

   localparam int DEPTH = 76800;

   logic        clk = 1'b0;
   logic        reset;
   logic [16:0] m0_address, m1_address;
   logic [3:0]  m0_byteenable, m1_byteenable;
   logic        m0_read, m0_write, m1_read, m1_write;
   logic [31:0] m0_writedata, m1_writedata;
   logic        m0_waitrequest, m1_waitrequest;
   logic [31:0] m0_readdata, m1_readdata;
   logic        m0_readdatavalid, m1_readdatavalid;
   logic        fill_start;
   logic [31:0] fill_value;
   logic        fill_busy, fill_done;
   logic [16:0] mem_address;
   logic [3:0]  mem_byteenable;
   logic        mem_chipselect, mem_write;
   logic [31:0] mem_writedata;
   logic [31:0] mem_readdata = '0;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   fb_mem_arbiter #(.ADDR_W(17), .DEPTH(DEPTH), .DATA_W(32)) dut (
      .clk(clk), .reset(reset),
      .m0_address(m0_address), .m0_byteenable(m0_byteenable),
      .m0_read(m0_read), .m0_write(m0_write), .m0_writedata(m0_writedata),
      .m0_waitrequest(m0_waitrequest), .m0_readdata(m0_readdata),
      .m0_readdatavalid(m0_readdatavalid),
      .m1_address(m1_address), .m1_byteenable(m1_byteenable),
      .m1_read(m1_read), .m1_write(m1_write), .m1_writedata(m1_writedata),
      .m1_waitrequest(m1_waitrequest), .m1_readdata(m1_readdata),
      .m1_readdatavalid(m1_readdatavalid),
      .fill_start(fill_start), .fill_value(fill_value),
      .fill_busy(fill_busy), .fill_done(fill_done),
      .mem_address(mem_address), .mem_byteenable(mem_byteenable),
      .mem_chipselect(mem_chipselect), .mem_write(mem_write),
      .mem_writedata(mem_writedata), .mem_readdata(mem_readdata)
   );

   // Frame memory attached to the DUT
   bit [31:0] mem [0:DEPTH-1];
   always @(posedge clk) begin
      if (mem_chipselect && int'(mem_address) < DEPTH) begin
         if (mem_write) begin
            for (int b = 0; b < 4; b++)
               if (mem_byteenable[b]) mem[mem_address][8*b +: 8] <= mem_writedata[8*b +: 8];
         end else begin
            mem_readdata <= mem[mem_address];
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   // phase: -1 idle, 0..DEPTH-1 index of the fill write this cycle, DEPTH = done cycle
   bit [31:0] ref_mem [0:DEPTH-1];
   int        m_phase = -1;
   int        m_last  = 1;
   bit [31:0] m_fill_val;
   bit        m_pend = 0;
   int        m_pend_id;
   bit [31:0] m_pend_val;
   bit [31:0] m_hold [2];

   int        w;
   bit        r0, r1;
   bit        wr_rd, wr_wr;
   int        wa;
   bit [3:0]  wbe;
   bit [31:0] wd;
   bit        e_cs, e_wr;
   int        e_addr;

   always @(negedge clk) begin
      if (reset) begin
         chk("rst_rdv0", m0_readdatavalid, 0);
         chk("rst_rdv1", m1_readdatavalid, 0);
         chk("rst_rd0", m0_readdata, 0);
         chk("rst_rd1", m1_readdata, 0);
         chk("rst_cs", mem_chipselect, 0);
         chk("rst_wr", mem_write, 0);
         chk("rst_busy", fill_busy, 0);
         chk("rst_done", fill_done, 0);
         m_phase = -1; m_last = 1; m_pend = 0;
         m_hold[0] = '0; m_hold[1] = '0;
      end else begin
         r0 = m0_read | m0_write;
         r1 = m1_read | m1_write;
         w  = -1;
         if (m_phase < 0) begin
            if (r0 && r1) w = (m_last == 0) ? 1 : 0;
            else if (r0) w = 0;
            else if (r1) w = 1;
         end
         wr_rd = (w == 1) ? m1_read : m0_read;
         wr_wr = (w == 1) ? m1_write : m0_write;
         wa    = int'((w == 1) ? m1_address : m0_address);
         wbe   = (w == 1) ? m1_byteenable : m0_byteenable;
         wd    = (w == 1) ? m1_writedata : m0_writedata;

         e_cs = 0; e_wr = 0; e_addr = 0;
         if (m_phase < 0 && w >= 0) begin
            e_cs = (wa < DEPTH); e_wr = wr_wr; e_addr = wa;
         end else if (m_phase >= 0 && m_phase < DEPTH) begin
            e_cs = 1; e_wr = 1; e_addr = m_phase;
         end

         chk("wait0", m0_waitrequest, (m_phase >= 0) ? 1 : (r0 && w != 0));
         chk("wait1", m1_waitrequest, (m_phase >= 0) ? 1 : (r1 && w != 1));
         chk("mem_cs", mem_chipselect, e_cs);
         chk("mem_wr", mem_write, e_wr);
         if (e_cs) chk("mem_addr", mem_address, e_addr);
         chk("busy", fill_busy, (m_phase >= 0 && m_phase < DEPTH));
         chk("done", fill_done, (m_phase == DEPTH));
         chk("rdv0", m0_readdatavalid, m_pend && m_pend_id == 0);
         chk("rdv1", m1_readdatavalid, m_pend && m_pend_id == 1);
         chk("rd0", m0_readdata, (m_pend && m_pend_id == 0) ? m_pend_val : m_hold[0]);
         chk("rd1", m1_readdata, (m_pend && m_pend_id == 1) ? m_pend_val : m_hold[1]);

         // advance model to next cycle
         if (m_pend) m_hold[m_pend_id] = m_pend_val;
         m_pend = 0;
         if (m_phase < 0) begin
            if (w >= 0) begin
               m_last = w;
               if (wr_wr) begin
                  if (wa < DEPTH)
                     for (int b = 0; b < 4; b++)
                        if (wbe[b]) ref_mem[wa][8*b +: 8] = wd[8*b +: 8];
               end else begin
                  m_pend = 1; m_pend_id = w;
                  m_pend_val = (wa < DEPTH) ? ref_mem[wa] : '0;
               end
            end
            if (fill_start) begin
               m_phase = 0; m_fill_val = fill_value;
            end
         end else if (m_phase < DEPTH) begin
            ref_mem[m_phase] = m_fill_val;
            m_phase++;
         end else begin
            m_phase = -1;
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic access(input int m, input bit rd, input bit wr, input logic [16:0] a,
                         input logic [3:0] be, input logic [31:0] d,
                         output int waits, output logic cs_g,
                         output logic rdv, output logic [31:0] rdata);
      bit granted;
      @(posedge clk); #1;
      if (m == 0) begin
         m0_read = rd; m0_write = wr; m0_address = a; m0_byteenable = be; m0_writedata = d;
      end else begin
         m1_read = rd; m1_write = wr; m1_address = a; m1_byteenable = be; m1_writedata = d;
      end
      waits = 0; granted = 0;
      while (!granted && waits <= 100) begin
         @(negedge clk);
         if (!((m == 0) ? m0_waitrequest : m1_waitrequest)) granted = 1;
         else waits++;
      end
      if (!granted) begin
         n_checks++; n_fail++;
         $display("FAIL access_timeout: got no grant expected grant within 100 cycles");
      end
      cs_g = mem_chipselect;
      @(posedge clk); #1;
      if (m == 0) begin m0_read = 0; m0_write = 0; end
      else begin m1_read = 0; m1_write = 0; end
      rdv = 0; rdata = '0;
      if (rd && !wr) begin
         @(negedge clk);
         rdv   = (m == 0) ? m0_readdatavalid : m1_readdatavalid;
         rdata = (m == 0) ? m0_readdata : m1_readdata;
      end
   endtask

   initial begin
      int waits, c0, c1, busy_cnt, cyc;
      logic cs_g, rdv;
      logic [31:0] rdata;
      bit seen;

      reset = 1;
      m0_address = '0; m1_address = '0; m0_byteenable = '0; m1_byteenable = '0;
      m0_read = 0; m0_write = 0; m1_read = 0; m1_write = 0;
      m0_writedata = '0; m1_writedata = '0; fill_start = 0; fill_value = '0;
      repeat (3) @(posedge clk);
      #1 reset = 0;

      // write then read back on m0
      access(0, 0, 1, 17'd5, 4'hF, 32'hDEADBEEF, waits, cs_g, rdv, rdata);
      chk("t1_wr_wait", waits, 0);
      access(0, 1, 0, 17'd5, 4'hF, 32'h0, waits, cs_g, rdv, rdata);
      chk("t1_rd_wait", waits, 0);
      chk("t1_rdv", rdv, 1);
      chk("t1_rdata", rdata, 32'hDEADBEEF);

      // both masters read for 6 cycles
      @(posedge clk); #1;
      m0_read = 1; m0_address = 17'd5; m1_read = 1; m1_address = 17'd6;
      c0 = 0; c1 = 0;
      for (int i = 0; i < 7; i++) begin
         @(negedge clk);
         c0 += int'(m0_readdatavalid);
         c1 += int'(m1_readdatavalid);
         @(posedge clk); #1;
         if (i == 5) begin m0_read = 0; m1_read = 0; end
      end
      chk("t2_rdv_cnt0", c0, 3);
      chk("t2_rdv_cnt1", c1, 3);

      // partial byte write on m1
      access(1, 0, 1, 17'd100, 4'hF, 32'hFFFFFFFF, waits, cs_g, rdv, rdata);
      access(1, 0, 1, 17'd100, 4'b0011, 32'h12345678, waits, cs_g, rdv, rdata);
      access(1, 1, 0, 17'd100, 4'hF, 32'h0, waits, cs_g, rdv, rdata);
      chk("t3_rdv", rdv, 1);
      chk("t3_rdata", rdata, 32'hFFFF5678);

      // out-of-range access
      access(0, 1, 0, 17'd76800, 4'hF, 32'h0, waits, cs_g, rdv, rdata);
      chk("t4_cs", cs_g, 0);
      chk("t4_rdv", rdv, 1);
      chk("t4_rdata", rdata, 32'h0);
      access(0, 0, 1, 17'd76800, 4'hF, 32'hCAFEF00D, waits, cs_g, rdv, rdata);
      chk("t4_wr_cs", cs_g, 0);
      access(0, 1, 0, 17'd0, 4'hF, 32'h0, waits, cs_g, rdv, rdata);
      chk("t4_addr0", rdata, 32'h0);

      // full fill with masters requesting throughout; a second start is ignored
      @(posedge clk); #1;
      fill_start = 1; fill_value = 32'h00FF00FF;
      @(negedge clk);
      chk("t5_busy_start", fill_busy, 0);
      @(posedge clk); #1;
      fill_start = 1; fill_value = 32'hA5A5A5A5;
      m0_read = 1; m0_address = 17'd0; m1_read = 1; m1_address = 17'd76799;
      busy_cnt = 0;
      @(negedge clk);
      busy_cnt += int'(fill_busy);
      @(posedge clk); #1;
      fill_start = 0; fill_value = '0;
      cyc = 0; seen = 0;
      while (!seen && cyc < 80000) begin
         @(negedge clk);
         if (fill_busy) busy_cnt++;
         if (fill_done) seen = 1;
         cyc++;
      end
      chk("t5_done_seen", seen, 1);
      chk("t5_busy_cycles", busy_cnt, 76800);
      @(posedge clk); #1;
      m0_read = 0; m1_read = 0;
      access(0, 1, 0, 17'd0, 4'hF, 32'h0, waits, cs_g, rdv, rdata);
      chk("t5_addr0", rdata, 32'h00FF00FF);
      access(1, 1, 0, 17'd76799, 4'hF, 32'h0, waits, cs_g, rdv, rdata);
      chk("t5_addr_last", rdata, 32'h00FF00FF);

      // reset after 1000 fill writes
      @(posedge clk); #1;
      fill_start = 1; fill_value = 32'hA5A5A5A5;
      @(posedge clk); #1;
      fill_start = 0;
      repeat (1000) @(posedge clk);
      #1 reset = 1;
      @(negedge clk);
      chk("t6_busy_after_rst", fill_busy, 0);
      @(posedge clk); #1;
      reset = 0;
      @(posedge clk); #1;
      m0_read = 1; m0_address = 17'd999; m1_read = 1; m1_address = 17'd1000;
      @(negedge clk);
      chk("t6_tie_wait0", m0_waitrequest, 0);
      chk("t6_tie_wait1", m1_waitrequest, 1);
      @(posedge clk); #1;
      m0_read = 0;
      @(negedge clk);
      chk("t6_rdv0", m0_readdatavalid, 1);
      chk("t6_addr999", m0_readdata, 32'hA5A5A5A5);
      chk("t6_wait1_grant", m1_waitrequest, 0);
      @(posedge clk); #1;
      m1_read = 0;
      @(negedge clk);
      chk("t6_rdv1", m1_readdatavalid, 1);
      chk("t6_addr1000", m1_readdata, 32'h00FF00FF);
      repeat (2) @(posedge clk);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
